// File: rtl/enemy_move_ctrl.sv
// Enemy tank direction controller: requests a random direction, holds it for
// HOLD_FRAMES frames or until a collision, and emits one move pulse per frame.
module enemy_move_ctrl #(
  parameter int unsigned HOLD_FRAMES = 64,
  parameter int unsigned CNT_BITS    = 10
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       enable,
  input  logic       startOfFrame,
  input  logic       collision,
  input  logic [1:0] rand_dir,
  output logic       rise,
  output logic [1:0] dir,
  output logic       move_en,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StMove} state_e;

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                col_flag_q, col_flag_d;
  logic [1:0]          prev_dir_q, prev_dir_d;
  logic [1:0]          dir_q, dir_d;
  logic                rise_q, rise_d;
  logic                move_en_q, move_en_d;
  logic                busy_q, busy_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      col_flag_q <= 1'b0;
      prev_dir_q <= 2'd0;
      dir_q      <= 2'd0;
      rise_q     <= 1'b0;
      move_en_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_flag_q <= col_flag_d;
      prev_dir_q <= prev_dir_d;
      dir_q      <= dir_d;
      rise_q     <= rise_d;
      move_en_q  <= move_en_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    col_flag_d = col_flag_q;
    prev_dir_d = prev_dir_q;
    dir_d      = dir_q;
    move_en_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StReq;
      end
      StReq: begin
        state_d = StWait;
      end
      StWait: begin
        // After a collision, never redraw the direction that just hit something.
        if (col_flag_q && (rand_dir == prev_dir_q)) dir_d = rand_dir + 2'd1;
        else                                          dir_d = rand_dir;
        cnt_d      = CNT_BITS'(HOLD_FRAMES);
        col_flag_d = 1'b0;
        state_d    = StMove;
      end
      StMove: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (collision) begin
          prev_dir_d = dir_q;
          col_flag_d = 1'b1;
          state_d    = StReq;
        end else if (startOfFrame) begin
          if (cnt_q != '0) begin
            cnt_d     = cnt_q - 1'b1;
            move_en_d = 1'b1;
          end else begin
            state_d = StReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so decode them from the next state.
    rise_d = (state_d == StReq);
    busy_d = (state_d == StReq) || (state_d == StWait);
  end

  assign rise    = rise_q;
  assign dir     = dir_q;
  assign move_en = move_en_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_enemy_move_ctrl.sv
// Directed self-checking bench for enemy_move_ctrl with a small random-generator model.
module tb_enemy_move_ctrl;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       enable = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       collision = 1'b0;
  logic [1:0] rand_dir = 2'd0;
  logic       rise;
  logic [1:0] dir;
  logic       move_en;
  logic       busy;

  logic [1:0] next_rand = 2'd0;
  logic       rise_prev = 1'b0;
  logic       rise_double = 1'b0;
  int         total = 0;
  int         bad = 0;

  enemy_move_ctrl #(
    .HOLD_FRAMES(4),
    .CNT_BITS   (10)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .enable      (enable),
    .startOfFrame(startOfFrame),
    .collision   (collision),
    .rand_dir    (rand_dir),
    .rise        (rise),
    .dir         (dir),
    .move_en     (move_en),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Generator model: dout updates on the edge where it sees rise high.
  always @(posedge clk) if (rise) rand_dir <= next_rand;

  always @(posedge clk) begin
    if (rise && rise_prev) rise_double <= 1'b1;
    rise_prev <= rise;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0; enable = 1'b0; startOfFrame = 1'b0; collision = 1'b0;
    tick(); tick();
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    resetN = 1'b0;
    #1;
    total++; if (rise !== 1'b0) begin bad++; $display("FAIL reset_rise got %b want 0", rise); end
    total++; if (dir !== 2'd0) begin bad++; $display("FAIL reset_dir got %0d want 0", dir); end
    total++; if (move_en !== 1'b0) begin bad++; $display("FAIL reset_move got %b want 0", move_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    tick();
    resetN = 1'b1; enable = 1'b1; next_rand = 2'd2;
    tick();
    total++; if (rise !== 1'b1) begin bad++; $display("FAIL t1_rise got %b want 1", rise); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy_req got %b want 1", busy); end
    tick();
    total++; if (rise !== 1'b0) begin bad++; $display("FAIL t1_rise_wait got %b want 0", rise); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy_wait got %b want 1", busy); end
    tick();
    total++; if (dir !== 2'd2) begin bad++; $display("FAIL t1_dir got %0d want 2", dir); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy_move got %b want 0", busy); end
  endtask

  task automatic test_hold();
    int pulses = 0;
    logic exp_mv;
    do_reset();
    next_rand = 2'd1; enable = 1'b1;
    tick(); tick(); tick();
    total++; if (dir !== 2'd1) begin bad++; $display("FAIL hold_dir1 got %0d want 1", dir); end
    for (int f = 0; f < 5; f++) begin
      if (f == 4) next_rand = 2'd3;
      exp_mv = (f < 4) ? 1'b1 : 1'b0;
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      total++;
      if (move_en !== exp_mv) begin
        bad++; $display("FAIL hold_move_f%0d got %b want %b", f, move_en, exp_mv);
      end
      total++;
      if (rise !== ~exp_mv) begin
        bad++; $display("FAIL hold_rise_f%0d got %b want %b", f, rise, ~exp_mv);
      end
      pulses += int'(move_en);
      for (int c = 0; c < 19; c++) begin
        tick();
        pulses += int'(move_en);
      end
    end
    total++; if (pulses != 4) begin bad++; $display("FAIL hold_pulses got %0d want 4", pulses); end
    total++; if (dir !== 2'd3) begin bad++; $display("FAIL hold_dir3 got %0d want 3", dir); end
  endtask

  task automatic collide(input logic [1:0] r);
    next_rand = r;
    collision = 1'b1;
    tick();
    collision = 1'b0;
    tick(); tick();
  endtask

  task automatic test_avoid();
    do_reset();
    next_rand = 2'd0; enable = 1'b1;
    tick(); tick(); tick();
    total++; if (dir !== 2'd0) begin bad++; $display("FAIL avoid_start got %0d want 0", dir); end
    collide(2'd0);
    total++; if (dir !== 2'd1) begin bad++; $display("FAIL avoid_same got %0d want 1", dir); end
    collide(2'd3);
    total++; if (dir !== 2'd3) begin bad++; $display("FAIL avoid_diff got %0d want 3", dir); end
    collide(2'd3);
    total++; if (dir !== 2'd0) begin bad++; $display("FAIL avoid_wrap got %0d want 0", dir); end
  endtask

  task automatic test_col_sof();
    int pulses = 0;
    next_rand = 2'd2;
    collision = 1'b1; startOfFrame = 1'b1;
    tick();
    collision = 1'b0; startOfFrame = 1'b0;
    total++; if (move_en !== 1'b0) begin bad++; $display("FAIL colsof_move got %b want 0", move_en); end
    total++; if (rise !== 1'b1) begin bad++; $display("FAIL colsof_rise got %b want 1", rise); end
    tick(); tick();
    total++; if (dir !== 2'd2) begin bad++; $display("FAIL colsof_dir got %0d want 2", dir); end
    next_rand = 2'd1;
    for (int f = 0; f < 5; f++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      pulses += int'(move_en);
      if (f == 4) begin
        total++;
        if (rise !== 1'b1) begin bad++; $display("FAIL colsof_reload_rise got %b want 1", rise); end
      end
      tick(); tick();
    end
    total++; if (pulses != 4) begin bad++; $display("FAIL colsof_pulses got %0d want 4", pulses); end
    total++; if (dir !== 2'd1) begin bad++; $display("FAIL colsof_dir2 got %0d want 1", dir); end
  endtask

  task automatic test_enable();
    int pulses = 0;
    enable = 1'b0;
    tick();
    for (int f = 0; f < 3; f++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      pulses += int'(move_en);
      for (int c = 0; c < 5; c++) begin
        tick();
        pulses += int'(move_en);
      end
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL en_pulses got %0d want 0", pulses); end
    total++; if (dir !== 2'd1) begin bad++; $display("FAIL en_dir_held got %0d want 1", dir); end
    next_rand = 2'd1;
    enable = 1'b1; startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    total++; if (rise !== 1'b1) begin bad++; $display("FAIL en_rise got %b want 1", rise); end
    total++; if (move_en !== 1'b0) begin bad++; $display("FAIL en_move got %b want 0", move_en); end
    tick(); tick();
    total++; if (dir !== 2'd1) begin bad++; $display("FAIL en_dir_new got %0d want 1", dir); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_draw();
    next_rand = 2'd2;
    collision = 1'b1;
    tick();
    collision = 1'b0;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_wait got %b want 1", busy); end
    resetN = 1'b0;
    #1;
    total++; if (rise !== 1'b0) begin bad++; $display("FAIL mid_rise got %b want 0", rise); end
    total++; if (dir !== 2'd0) begin bad++; $display("FAIL mid_dir got %0d want 0", dir); end
    total++; if (move_en !== 1'b0) begin bad++; $display("FAIL mid_move got %b want 0", move_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got %b want 0", busy); end
    tick();
    resetN = 1'b1;
    tick();
    total++; if (rise !== 1'b1) begin bad++; $display("FAIL mid_rerise got %b want 1", rise); end
    tick(); tick();
    total++; if (dir !== 2'd2) begin bad++; $display("FAIL mid_redraw got %0d want 2", dir); end
    total++;
    if (rise_double !== 1'b0) begin
      bad++; $display("FAIL rise_spacing got %b want 0", rise_double);
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_avoid();
    test_col_sof();
    test_enable();
    test_reset_mid_draw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
